// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid
// buffer, flush-to-bubble and a saturating backpressure counter.
module pipe_skid_stage #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CNT_W       = 16,
    parameter bit          BUBBLE_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_nxt;
    logic             in_xfer;
    logic             out_xfer;

    // All handshake outputs derive only from registered state.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign out_data  = main_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Next-state and payload steering.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            if (BUBBLE_ZERO) begin
                main_nxt = '0;
                skid_nxt = '0;
            end
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_nxt  = in_data;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_nxt = in_data;
                    end else if (in_xfer) begin
                        skid_nxt  = in_data;
                        state_nxt = FULL;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_nxt  = skid_q;
                        state_nxt = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State and payload registers; reset overrides flush and handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            if (BUBBLE_ZERO) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Saturating count of cycles where a valid output is held off; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
